// File: rtl/lcd_pattern_gen.sv
// lcd_pattern_gen: per-frame selectable RGB565 test patterns, aligned with re-registered LCD timing.
module lcd_pattern_gen #(
  parameter int H_ACTIVE        = 480,
  parameter int V_ACTIVE        = 272,
  parameter int BAR_W           = 60,
  parameter int CHECK_SHIFT     = 4,
  parameter int SCROLL_STEP     = 2,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic       PixelClk,
  input  logic       RST,
  input  logic [1:0] mode_sel,
  input  logic       in_de,
  input  logic       in_hsync,
  input  logic       in_vsync,
  output logic       LCD_DE,
  output logic       LCD_HSYNC,
  output logic       LCD_VSYNC,
  output logic [4:0] LCD_R,
  output logic [5:0] LCD_G,
  output logic [4:0] LCD_B,
  output logic [7:0] frame_cnt
);
  localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);
  logic [8:0]  x, y, bar_pos;
  logic [1:0]  mode;
  logic        prev_de, prev_vs, valid, vs_edge;
  logic [9:0]  xw, d, bar_sum, bar_nx;
  logic [2:0]  idx;
  logic [15:0] bar_rgb, grad_rgb, chk_rgb, mbar_rgb, pix;
  assign vs_edge = (prev_vs == SYNC_IDLE) && (in_vsync != SYNC_IDLE);
  assign xw      = {1'b0, x};
  // compare chain instead of a divider; anything past the 7th bar stays black
  always_comb begin
    idx = xw < 10'(BAR_W)     ? 3'd0 :
          xw < 10'(2 * BAR_W) ? 3'd1 :
          xw < 10'(3 * BAR_W) ? 3'd2 :
          xw < 10'(4 * BAR_W) ? 3'd3 :
          xw < 10'(5 * BAR_W) ? 3'd4 :
          xw < 10'(6 * BAR_W) ? 3'd5 :
          xw < 10'(7 * BAR_W) ? 3'd6 : 3'd7;
    bar_rgb  = {{5{~idx[1]}}, {6{~idx[2]}}, {5{~idx[0]}}};
    grad_rgb = {x[8:4], x[8:3], 5'd31 - x[8:4]};
    chk_rgb  = (x[CHECK_SHIFT] ^ y[CHECK_SHIFT]) ? 16'h0000 : 16'hFFFF;
    d        = (x >= bar_pos) ? xw - {1'b0, bar_pos} : xw + 10'(H_ACTIVE) - {1'b0, bar_pos};
    mbar_rgb = (d < 10'(BAR_W)) ? 16'hFFFF : 16'h001F;
    pix      = (!in_de || !valid) ? 16'h0000 :
               mode == 2'd0 ? bar_rgb :
               mode == 2'd1 ? grad_rgb :
               mode == 2'd2 ? chk_rgb : mbar_rgb;
    bar_sum  = {1'b0, bar_pos} + 10'(SCROLL_STEP);
    bar_nx   = (bar_sum >= 10'(H_ACTIVE)) ? bar_sum - 10'(H_ACTIVE) : bar_sum;
  end
  // valid stays low after reset so no half-initialised pattern reaches the panel
  always_ff @(posedge PixelClk or posedge RST) begin
    if (RST) begin
      LCD_DE                 <= 1'b0;
      LCD_HSYNC              <= SYNC_IDLE;
      LCD_VSYNC              <= SYNC_IDLE;
      {LCD_R, LCD_G, LCD_B}  <= 16'h0000;
      frame_cnt              <= 8'd0;
      x                      <= 9'd0;
      y                      <= 9'd0;
      mode                   <= 2'd0;
      bar_pos                <= 9'd0;
      prev_de                <= 1'b0;
      prev_vs                <= SYNC_IDLE;
      valid                  <= 1'b0;
    end else begin
      LCD_DE                 <= in_de;
      LCD_HSYNC              <= in_hsync;
      LCD_VSYNC              <= in_vsync;
      {LCD_R, LCD_G, LCD_B}  <= pix;
      prev_de                <= in_de;
      prev_vs                <= in_vsync;
      x                      <= !in_de ? 9'd0 : (x < 9'(H_ACTIVE - 1)) ? x + 9'd1 : x;
      if (vs_edge) begin
        y         <= 9'd0;
        mode      <= mode_sel;
        frame_cnt <= frame_cnt + 8'd1;
        bar_pos   <= bar_nx[8:0];
        valid     <= 1'b1;
      end else if (prev_de && !in_de && y < 9'(V_ACTIVE - 1)) begin
        y <= y + 9'd1;
      end
    end
  end
endmodule

// File: tb/tb_lcd_pattern_gen.sv
// tb_lcd_pattern_gen: directed frames/lines with a scoreboard of expected panel outputs.
module tb_lcd_pattern_gen;
  logic       PixelClk = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] mode_sel = 2'd0;
  logic       in_de = 1'b0, in_hsync = 1'b1, in_vsync = 1'b1;
  logic       LCD_DE, LCD_HSYNC, LCD_VSYNC;
  logic [4:0] LCD_R, LCD_B;
  logic [5:0] LCD_G;
  logic [7:0] frame_cnt;
  int checks = 0, failures = 0;
  int sw_at = -1;
  logic [1:0] sw_mode = 2'd0;
  typedef struct {logic [2:0] ctrl; logic chk; logic [15:0] rgb; int id;} exp_t;
  exp_t sb[$];
  int pt_x[$];
  logic [15:0] pt_rgb[$];

  lcd_pattern_gen dut (
    .PixelClk(PixelClk), .RST(RST), .mode_sel(mode_sel),
    .in_de(in_de), .in_hsync(in_hsync), .in_vsync(in_vsync),
    .LCD_DE(LCD_DE), .LCD_HSYNC(LCD_HSYNC), .LCD_VSYNC(LCD_VSYNC),
    .LCD_R(LCD_R), .LCD_G(LCD_G), .LCD_B(LCD_B), .frame_cnt(frame_cnt)
  );

  always #5 PixelClk = ~PixelClk;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic de, input logic hs, input logic vs, input logic c,
                     input logic [15:0] rgb, input int id);
    exp_t e;
    @(negedge PixelClk);
    in_de = de; in_hsync = hs; in_vsync = vs;
    e.ctrl = {de, hs, vs}; e.chk = c; e.rgb = rgb; e.id = id;
    sb.push_back(e);
    @(posedge PixelClk);
    #1;
    e = sb.pop_front();
    chk16($sformatf("ctrl@%0d", e.id), {13'd0, LCD_DE, LCD_HSYNC, LCD_VSYNC}, {13'd0, e.ctrl});
    if (e.chk) chk16($sformatf("rgb@%0d", e.id), {LCD_R, LCD_G, LCD_B}, e.rgb);
  endtask

  task automatic pt(input int px, input logic [15:0] rgb);
    pt_x.push_back(px);
    pt_rgb.push_back(rgb);
  endtask

  task automatic line(input int n);
    for (int i = 0; i < n; i++) begin
      logic hit;
      logic [15:0] r;
      hit = 1'b0; r = 16'h0;
      for (int j = 0; j < pt_x.size(); j++) if (pt_x[j] == i) begin hit = 1'b1; r = pt_rgb[j]; end
      if (i == sw_at) mode_sel = sw_mode;
      cyc(1'b1, 1'b1, 1'b1, hit, r, i);
    end
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'h0, -2);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h0, -3);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, -2);
    pt_x.delete();
    pt_rgb.delete();
    sw_at = -1;
  endtask

  task automatic vs_pulse();
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h0, -4);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'h0, -5);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge PixelClk);
    #1;
    chk16("reset_ctrl", {13'd0, LCD_DE, LCD_HSYNC, LCD_VSYNC}, 16'h0003);
    chk16("reset_rgb", {LCD_R, LCD_G, LCD_B}, 16'h0);
    chk16("reset_fc", {8'd0, frame_cnt}, 16'd0);
    @(negedge PixelClk) RST = 1'b0;
    mode_sel = 2'd0;
    vs_pulse();
    chk16("fc_1", {8'd0, frame_cnt}, 16'd1);
    pt(0, 16'hFFFF); pt(59, 16'hFFFF); pt(60, 16'hFFE0); pt(479, 16'h0000);
    line(480);
    mode_sel = 2'd1;
    vs_pulse();
    pt(0, 16'h001F); pt(256, 16'h840F);
    line(480);
    mode_sel = 2'd2;
    vs_pulse();
    chk16("fc_3", {8'd0, frame_cnt}, 16'd3);
    pt(0, 16'hFFFF); pt(16, 16'h0000);
    line(20);
    repeat (15) line(20);
    pt(0, 16'h0000); pt(16, 16'hFFFF);
    line(20);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0, i);
    @(negedge PixelClk);
    #2 RST = 1'b1;
    #1;
    chk16("rst_mid_ctrl", {13'd0, LCD_DE, LCD_HSYNC, LCD_VSYNC}, 16'h0003);
    chk16("rst_mid_rgb", {LCD_R, LCD_G, LCD_B}, 16'h0);
    chk16("rst_mid_fc", {8'd0, frame_cnt}, 16'd0);
    @(negedge PixelClk) in_de = 1'b0;
    @(negedge PixelClk) RST = 1'b0;
    mode_sel = 2'd3;
    pt(0, 16'h0000); pt(50, 16'h0000);
    line(100);
    vs_pulse();
    chk16("fc_after_rst", {8'd0, frame_cnt}, 16'd1);
    pt(1, 16'h001F); pt(2, 16'hFFFF); pt(61, 16'hFFFF); pt(62, 16'h001F);
    line(70);
    vs_pulse();
    vs_pulse();
    pt(5, 16'h001F); pt(6, 16'hFFFF); pt(65, 16'hFFFF); pt(66, 16'h001F);
    line(70);
    repeat (236) vs_pulse();
    chk16("fc_239", {8'd0, frame_cnt}, 16'd239);
    pt(0, 16'hFFFF); pt(57, 16'hFFFF); pt(58, 16'h001F);
    pt(477, 16'h001F); pt(478, 16'hFFFF); pt(479, 16'hFFFF);
    line(480);
    mode_sel = 2'd0;
    vs_pulse();
    repeat (100) line(10);
    sw_mode = 2'd2; sw_at = 10;
    pt(0, 16'hFFFF); pt(70, 16'hFFE0);
    line(130);
    pt(16, 16'hFFFF); pt(70, 16'hFFE0);
    line(130);
    vs_pulse();
    chk16("fc_241", {8'd0, frame_cnt}, 16'd241);
    pt(0, 16'hFFFF); pt(16, 16'h0000); pt(70, 16'hFFFF);
    line(130);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lcd_pattern_gen.md
Name: lcd_pattern_gen

Overview:
Pixel-source stage sitting directly downstream of the LCD timing generator and driving the panel RGB pins.
- Consumes the timing generator's DE/HSYNC/VSYNC.
- Tracks pixel coordinates and selects one of four test patterns, latched per frame.
- Emits RGB565 with DE/HSYNC/VSYNC re-registered so all panel signals stay aligned.

Parameters:
H_ACTIVE, 480, active pixels per line (must be ≤ 512)
V_ACTIVE, 272, active lines per frame
BAR_W, 60, width of one colour bar and of the moving bar, in pixels
CHECK_SHIFT, 4, checker square size = 2^CHECK_SHIFT pixels
SCROLL_STEP, 2, moving-bar advance per frame in pixels (< H_ACTIVE)
SYNC_ACTIVE_LOW, 1, polarity of in/out HSYNC and VSYNC

Ports:
PixelClk  in  1  pixel clock (9 MHz)
RST  in  1  asynchronous active-high reset
mode_sel  in  2  requested pattern: 0 colour bars, 1 gradient, 2 checker, 3 moving bar
in_de  in  1  data enable from timing generator
in_hsync  in  1  horizontal sync from timing generator
in_vsync  in  1  vertical sync from timing generator
LCD_DE  out  1  registered data enable
LCD_HSYNC  out  1  registered hsync
LCD_VSYNC  out  1  registered vsync
LCD_R  out  5  red
LCD_G  out  6  green
LCD_B  out  5  blue
frame_cnt  out  8  frames seen since reset, wraps 255→0

Behaviour:
- Reset (async assert, sync release):
  - LCD_DE=0; LCD_R/G/B=0; frame_cnt=0.
  - LCD_HSYNC/LCD_VSYNC at inactive level (1 when SYNC_ACTIVE_LOW=1).
  - Internal state: x=0, y=0, active mode=0, bar_pos=0, previous-DE and previous-VSYNC registers = inactive.
- Latency:
  - LCD_DE/HSYNC/VSYNC equal the corresponding inputs delayed exactly 1 PixelClk.
  - RGB is computed from the current-cycle in_de and (x,y) and registered in the same cycle, so it is aligned with LCD_DE.
- Frame start: VSYNC assertion edge (inactive→active on in_vsync, detected against the previous sample). On that cycle:
  - y←0
  - active mode←mode_sel
  - frame_cnt←frame_cnt+1
  - bar_pos←bar_pos+SCROLL_STEP, minus H_ACTIVE if result ≥ H_ACTIVE
- Mode changes: mode_sel changes mid-frame are ignored until the next frame start.
- x counter:
  - Cleared whenever in_de=0.
  - Increments on each in_de=1 cycle.
  - Saturates at H_ACTIVE-1 if DE runs long.
- y counter:
  - Increments on each in_de falling edge.
  - Saturates at V_ACTIVE-1.
- Blanking: when in_de=0, next LCD_R/G/B = 0.
- Pattern 0, colour bars:
  - idx = x / BAR_W, clamped to 7 (implemented as a compare chain, not a divider).
  - idx order: white, yellow, cyan, green, magenta, red, blue, black.
  - Full scale R=31, G=63, B=31.
- Pattern 1, gradient: R=x[8:4], G=x[8:3], B=31−x[8:4].
- Pattern 2, checker: p = x[CHECK_SHIFT] XOR y[CHECK_SHIFT]; p=0 → white, p=1 → black.
- Pattern 3, moving bar:
  - d = x−bar_pos, plus H_ACTIVE if negative.
  - d < BAR_W → white; otherwise blue (R=0, G=0, B=31).
  - The bar wraps across the right edge onto the left edge.
- Simultaneous events: VSYNC edge coinciding with in_de=1 still performs the frame-start updates; that pixel uses the old mode.
- Sync polarity: with SYNC_ACTIVE_LOW=0, all sync polarities and reset levels invert.
- Reset mid-line: outputs go to reset values immediately; after release, the pattern is garbage-free (black) until the next VSYNC edge; x/y resync on the next DE.

Test Plan:
- Reset, then feed a 480-pixel DE line with mode_sel=0 → LCD_DE rises 1 cycle after in_de.
  - Pixel 0 = R31 G63 B31.
  - Pixel 60 = R31 G63 B0.
  - Pixel 479 = 0/0/0.
  - RGB = 0 while DE low.
- mode_sel=1, x=256 → R=16, G=32, B=15; x=0 → 0/0/31.
- mode_sel=2, CHECK_SHIFT=4: (x,y)=(0,0) white; (16,0) black; (16,16) white; line 16 reached via 16 DE falling edges.
- Moving bar:
  - mode_sel=3; after 3 VSYNC edges bar_pos=6; x=6..65 white, x=66 blue.
  - Force bar_pos=478 (after 239 frames): x=478,479,0..57 white; x=58 blue.
  - frame_cnt=239.
- Mode change mid-frame:
  - Switch mode_sel 0→2 during line 100 → output remains bars for the rest of the frame.
  - Checker appears from the first DE after the next VSYNC edge.
- Reset asserted mid-line during DE:
  - LCD_DE=0, RGB=0 and syncs inactive in the same cycle.
  - After release plus one full frame, the pattern is correct and frame_cnt counts from 1.
